vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have these parameters, one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync pulse width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch.
- HS_POL, 0, active level of hsync.
- VS_POL, 0, active level of vsync.
- TILE, 10, tile edge in pixels.
- PIPE_DLY, 1, extra cycles on hsync/vsync/de, range 0..7.
- CW, 11, counter/coordinate width.

Ports (name, direction, width, meaning):
REQ-002 clk_25m  in  1  pixel clock; single clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pix_en  in  1  pixel-advance enable; counters hold when low.
REQ-005 hsync  out  1  horizontal sync at HS_POL level during the pulse.
REQ-006 vsync  out  1  vertical sync at VS_POL level during the pulse.
REQ-007 de  out  1  display enable; high in the visible area (drives dac_blank).
REQ-008 x, y  out  CW each  visible pixel coordinate; 0 outside the visible area.
REQ-009 tile_x, tile_y  out  CW each  coordinate divided by TILE.
REQ-010 off_x, off_y  out  CW each  coordinate modulo TILE.
REQ-011 line_start, frame_start  out  1 each  single-cycle pulses.

Function
REQ-012 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-013 h_cnt SHALL run 0..H_TOTAL-1 and advance only when pix_en=1, wrapping to 0 after H_TOTAL-1; there SHALL be no H_TOTAL state.
REQ-014 v_cnt SHALL advance only when h_cnt wraps, run 0..V_TOTAL-1, and wrap to 0.
REQ-015 h_cnt=0 / v_cnt=0 SHALL be the first visible pixel/line; the order within a line or frame SHALL be active, FP, sync, BP.
REQ-016 Raw de SHALL be (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
REQ-017 Raw hsync SHALL be active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); raw vsync SHALL be active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-018 x, y, tile_*, off_* SHALL be registered outputs with 1-cycle latency from the counter state.
REQ-019 hsync, vsync, de, line_start and frame_start SHALL have 1+PIPE_DLY cycles latency, so that renderer output registered PIPE_DLY cycles after x/y aligns with de.
REQ-020 tile/offset values SHALL come from incremental counters, with no divider: off_x increments and wraps to 0 at TILE-1 while tile_x increments; both clear at h_cnt=0. tile_y/off_y behave the same per visible line and clear at v_cnt=0.
REQ-021 line_start SHALL pulse when h_cnt=0 with pix_en=1; frame_start SHALL pulse when h_cnt=0, v_cnt=0 and pix_en=1.
REQ-022 With pix_en=0, all outputs SHALL hold their values and no pulse SHALL repeat.
REQ-023 Simultaneous h and v wrap SHALL yield h_cnt=0, v_cnt=0 on the same cycle.

Reset
REQ-024 On rst=1 at a clk_25m edge, h_cnt and v_cnt SHALL be set to 0, as SHALL x, y, tile_*, off_*, de, line_start and frame_start; hsync SHALL be set to ~HS_POL and vsync to ~VS_POL (inactive), and the delay line SHALL be flushed to the inactive values.
REQ-025 Reset mid-frame SHALL restart at pixel (0,0); the first frame_start SHALL occur 1+PIPE_DLY cycles after the first enabled cycle following rst deassertion.

Structure
REQ-026 The 640x480@60 defaults and the H_TOTAL/V_TOTAL derivations SHALL live in shared package vga_pkg, to be reused by the tank renderer.
REQ-027 The sync/de delay SHALL be one sub-module, sig_delay (parameter width and depth; depth 0 = wire).
REQ-028 The block SHALL contain no PLL and no clock generation.

Verification
REQ-029 Defaults, pix_en=1, run 2 frames: hsync low for exactly 96 cycles every 800, vsync low for exactly 1600 cycles every 420000, and 307200 de cycles per frame.
REQ-030 Coordinate check: at the first de cycle x=0, y=0; at the last de cycle of the frame x=639, y=479, tile_x=63, off_x=9, tile_y=47, off_y=9.
REQ-031 Alignment: PIPE_DLY=0 and PIPE_DLY=3; de rises exactly 0 and 3 cycles after x=0 first appears.
REQ-032 pix_en toggled 1,0,1,0 pseudo-randomly: the output sequence SHALL equal the pix_en=1 sequence with holds inserted; no duplicate pulses.
REQ-033 rst asserted at h_cnt=400, v_cnt=200 for one cycle: the next outputs SHALL be the reset values, then frame_start after 1+PIPE_DLY cycles.
REQ-034 Parameter set 800x600 (H 40/128/88, V 1/4/23, HS_POL=1, VS_POL=1): period 1056x628 and active-high sync widths 128 and 4.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, line/frame total helper and the
// sync/de bundle that travels through the output delay line. Also intended for
// use by the tank renderer so both sides agree on the raster geometry.
package vga_pkg;

  // Sum of the four segments of one line (or frame): active, FP, sync, BP.
  function automatic int unsigned seg_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_TILE     = 10;
  localparam int unsigned DEF_PIPE_DLY = 1;
  localparam int unsigned DEF_CW       = 11;

  localparam int unsigned DEF_H_TOTAL =
    seg_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);  // 800
  localparam int unsigned DEF_V_TOTAL =
    seg_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);  // 525

  // Signals that share the 1+PIPE_DLY output latency.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } sync_t;

endpackage

// File: rtl/sig_delay.sv
// sig_delay: enable-gated shift register of DEPTH stages, WIDTH bits wide.
// DEPTH = 0 is a plain wire. Stages load RST_VAL on synchronous reset.
// Ports:
//   clk  in  1      clock
//   rst  in  1      synchronous active-high reset
//   en   in  1      shift enable; contents hold when low
//   d    in  WIDTH  input word
//   q    out WIDTH  word delayed by DEPTH enabled cycles
module sig_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH*WIDTH-1:0] pipe;

    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst)     pipe <= RST_VAL;
        else if (en) pipe <= d;
      end
    end else begin : g_many
      // Newest word enters at the bottom, oldest leaves at the top.
      always_ff @(posedge clk) begin
        if (rst)     pipe <= {DEPTH{RST_VAL}};
        else if (en) pipe <= {pipe[(DEPTH-1)*WIDTH-1:0], d};
      end
    end

    assign q = pipe[DEPTH*WIDTH-1 -: WIDTH];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel coordinates and tile split.
// Counters advance on pix_en; x/y/tile/off are registered one cycle after the
// counter state, sync/de/pulses a further PIPE_DLY enabled cycles later so a
// renderer registered PIPE_DLY cycles after x/y lines up with de.
// Ports:
//   clk_25m              in  1   pixel clock
//   rst                  in  1   synchronous active-high reset
//   pix_en               in  1   pixel advance enable
//   hsync, vsync         out 1   sync pulses at HS_POL / VS_POL when active
//   de                   out 1   display enable (visible area)
//   x, y                 out CW  visible coordinate, 0 outside visible area
//   tile_x, tile_y       out CW  coordinate / TILE
//   off_x, off_y         out CW  coordinate % TILE
//   line_start           out 1   one-cycle pulse at the start of each line
//   frame_start          out 1   one-cycle pulse at the start of each frame
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned TILE     = DEF_TILE,
  parameter int unsigned PIPE_DLY = DEF_PIPE_DLY,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk_25m,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] tile_x,
  output logic [CW-1:0] tile_y,
  output logic [CW-1:0] off_x,
  output logic [CW-1:0] off_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL  = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0,
                                  line_start: 1'b0, frame_start: 1'b0};

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] tx_cnt, ox_cnt, ty_cnt, oy_cnt;
  logic          h_last, v_last, ox_last, oy_last, de_raw;
  logic          adv_q;
  sync_t         raw, stage1, dly_q;

  assign h_last  = (h_cnt == CW'(H_TOTAL - 1));
  assign v_last  = (v_cnt == CW'(V_TOTAL - 1));
  assign ox_last = (ox_cnt == CW'(TILE - 1));
  assign oy_last = (oy_cnt == CW'(TILE - 1));
  assign de_raw  = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));

  // Raster counters plus tile/offset counters that track them without a divider.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      tx_cnt <= '0;
      ox_cnt <= '0;
      ty_cnt <= '0;
      oy_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt  <= '0;
        tx_cnt <= '0;
        ox_cnt <= '0;
        if (v_last) begin
          v_cnt  <= '0;
          ty_cnt <= '0;
          oy_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + CW'(1);
          if (oy_last) begin
            oy_cnt <= '0;
            ty_cnt <= ty_cnt + CW'(1);
          end else begin
            oy_cnt <= oy_cnt + CW'(1);
          end
        end
      end else begin
        h_cnt <= h_cnt + CW'(1);
        if (ox_last) begin
          ox_cnt <= '0;
          tx_cnt <= tx_cnt + CW'(1);
        end else begin
          ox_cnt <= ox_cnt + CW'(1);
        end
      end
    end
  end

  // Undelayed sync/de/pulse levels decoded from the counter state.
  always_comb begin
    raw             = SYNC_IDLE;
    raw.de          = de_raw;
    raw.line_start  = (h_cnt == '0);
    raw.frame_start = (h_cnt == '0) && (v_cnt == '0);
    if ((h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END))) raw.hsync = HS_POL;
    if ((v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END))) raw.vsync = VS_POL;
  end

  // First output stage: coordinates and the head of the sync delay line.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      tile_x <= '0;
      tile_y <= '0;
      off_x  <= '0;
      off_y  <= '0;
      stage1 <= SYNC_IDLE;
      adv_q  <= 1'b0;
    end else begin
      adv_q <= pix_en;
      if (pix_en) begin
        x      <= de_raw ? h_cnt  : '0;
        y      <= de_raw ? v_cnt  : '0;
        tile_x <= de_raw ? tx_cnt : '0;
        tile_y <= de_raw ? ty_cnt : '0;
        off_x  <= de_raw ? ox_cnt : '0;
        off_y  <= de_raw ? oy_cnt : '0;
        stage1 <= raw;
      end
    end
  end

  sig_delay #(
    .WIDTH  ($bits(sync_t)),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(SYNC_IDLE)
  ) u_sync_dly (
    .clk(clk_25m),
    .rst(rst),
    .en (pix_en),
    .d  (stage1),
    .q  (dly_q)
  );

  assign hsync = dly_q.hsync;
  assign vsync = dly_q.vsync;
  assign de    = dly_q.de;

  // The delay line holds while pix_en is low; qualifying with adv_q keeps the
  // pulses to one cycle instead of stretching them across the hold.
  assign line_start  = dly_q.line_start  & adv_q;
  assign frame_start = dly_q.frame_start & adv_q;

endmodule
